// File: rtl/w4a8_tile_acc_engine.sv
// ---------------------------------------------------------------------------
// w4a8_tile_acc_engine
//
// W4A8 GEMM tile engine. Computes an M x N output tile
//   C = C_init + sum over ksteps of (A_beat x B_beat^T)
// where every accepted beat carries a K-wide slice of int8 activations for
// all M rows and int4 weights for all N columns.
//
// Datapath per accepted beat (fixed latency, 1 beat/cycle sustained):
//   stage 1 (registered): element products a(i,k) * b(j,k)
//   stage 2 (registered): exact K-way sum per output element
//   accumulate          : saturating add into the accumulator tile
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            begin a tile (sampled only in IDLE)
//   cfg_ksteps       beats in this tile, latched on start
//   cfg_b_unsigned   1: weights 0..15, 0: two's complement; latched on start
//   cfg_init_en      1: seed accumulators from init_data, 0: seed with zero
//   init_data        accumulator seed, element (i,j) at (i*N+j)*ACC_WIDTH
//   in_valid/in_ready beat handshake
//   a_data           activations, element (i,k) at (i*K+k)*A_WIDTH
//   b_data           weights, element (j,k) at (j*K+k)*B_WIDTH
//   out_valid/out_ready result handshake; result held until taken
//   out_data         result tile, same packing as init_data
//   sat              sticky: some accumulator clamped during this tile
//   busy             engine not idle
// ---------------------------------------------------------------------------
module w4a8_tile_acc_engine #(
  parameter int A_WIDTH    = 8,
  parameter int B_WIDTH    = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int K          = 8,
  parameter int MAX_KSTEPS = 256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [$clog2(MAX_KSTEPS+1)-1:0]      cfg_ksteps,
  input  logic                                 cfg_b_unsigned,
  input  logic                                 cfg_init_en,
  input  logic [M*N*ACC_WIDTH-1:0]             init_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [M*K*A_WIDTH-1:0]               a_data,
  input  logic [N*K*B_WIDTH-1:0]               b_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [M*N*ACC_WIDTH-1:0]             out_data,
  output logic                                 sat,
  output logic                                 busy
);

  localparam int KS_W = $clog2(MAX_KSTEPS+1);
  localparam int P_W  = A_WIDTH + B_WIDTH + 1;    // product width
  localparam int S_W  = P_W + $clog2(K);          // exact K-way sum width
  localparam int MN   = M * N;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  state_t          state_reg;
  logic [KS_W-1:0] ksteps_reg;
  logic [KS_W-1:0] count_reg;
  logic            b_unsigned_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic            sat_reg;

  // Valid shadows for the two pipeline stages; bubbles never reach the
  // accumulators because every stage only advances on its own valid bit.
  logic            v1_reg;
  logic            v2_reg;

  logic            beat_fire;
  logic            load_acc;
  logic            copy_out;
  logic [MN-1:0]   clamp_vec;

  assign beat_fire = in_valid && in_ready_reg;
  assign load_acc  = (state_reg == IDLE) && start;
  // All accepted beats have landed once both stages are empty.
  assign copy_out  = (state_reg == DRAIN) && !v1_reg && !v2_reg;

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sat       = sat_reg;
  assign busy      = (state_reg != IDLE);

  // Product of one activation and one weight. The weight is widened to
  // B_WIDTH+1 bits (zero- or sign-extended) so it is always a signed value;
  // the product of an A_WIDTH and a (B_WIDTH+1)-bit signed number fits in
  // P_W bits, so modular arithmetic at P_W bits is exact.
  function automatic logic [P_W-1:0] mul_elem(input logic [A_WIDTH-1:0] a,
                                              input logic [B_WIDTH-1:0] b,
                                              input logic               b_uns);
    logic [P_W-1:0] ax;
    logic [P_W-1:0] bx;
    ax = {{(P_W-A_WIDTH){a[A_WIDTH-1]}}, a};
    bx = b_uns ? {{(P_W-B_WIDTH){1'b0}}, b}
               : {{(P_W-B_WIDTH){b[B_WIDTH-1]}}, b};
    return ax * bx;
  endfunction

  // -------------------------------------------------------------------------
  // Control
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ksteps_reg     <= '0;
      count_reg      <= '0;
      b_unsigned_reg <= 1'b0;
      in_ready_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      sat_reg        <= 1'b0;
      v1_reg         <= 1'b0;
      v2_reg         <= 1'b0;
    end else begin
      v1_reg <= beat_fire;
      v2_reg <= v1_reg;
      if (|clamp_vec) begin
        sat_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            ksteps_reg     <= cfg_ksteps;
            b_unsigned_reg <= cfg_b_unsigned;
            count_reg      <= '0;
            sat_reg        <= 1'b0;
            if (cfg_ksteps == '0) begin
              state_reg <= DRAIN;
            end else begin
              state_reg    <= RUN;
              in_ready_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (beat_fire) begin
            count_reg <= count_reg + KS_W'(1);
            if (count_reg + KS_W'(1) == ksteps_reg) begin
              in_ready_reg <= 1'b0;
              state_reg    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (copy_out) begin
            out_valid_reg <= 1'b1;
            state_reg     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // One datapath cell per output element (i,j)
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < MN; gi++) begin : g_cell
      localparam int I = gi / N;
      localparam int J = gi % N;

      logic [P_W-1:0]       prod_reg [K];
      logic [S_W-1:0]       sum_next;
      logic [S_W-1:0]       sum_reg;
      logic [ACC_WIDTH-1:0] acc_reg;
      logic [ACC_WIDTH:0]   acc_wide;
      logic [ACC_WIDTH-1:0] sat_val;
      logic [ACC_WIDTH-1:0] out_reg;

      // Stage 1: products for this (i,j) across the K lanes.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < K; k++) begin
            prod_reg[k] <= '0;
          end
        end else if (beat_fire) begin
          for (int k = 0; k < K; k++) begin
            prod_reg[k] <= mul_elem(a_data[(I*K+k)*A_WIDTH +: A_WIDTH],
                                    b_data[(J*K+k)*B_WIDTH +: B_WIDTH],
                                    b_unsigned_reg);
          end
        end
      end

      // Stage 2: exact sum; S_W has log2(K) guard bits so no overflow.
      always_comb begin
        sum_next = '0;
        for (int k = 0; k < K; k++) begin
          sum_next = sum_next + {{(S_W-P_W){prod_reg[k][P_W-1]}}, prod_reg[k]};
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sum_reg <= '0;
        end else if (v1_reg) begin
          sum_reg <= sum_next;
        end
      end

      // One extra bit of headroom: the add overflowed exactly when the two
      // top bits of the widened result disagree.
      always_comb begin
        acc_wide = {acc_reg[ACC_WIDTH-1], acc_reg}
                 + {{(ACC_WIDTH+1-S_W){sum_reg[S_W-1]}}, sum_reg};
        sat_val  = acc_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end

      assign clamp_vec[gi] = v2_reg && (acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1]);

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_reg <= '0;
        end else if (load_acc) begin
          acc_reg <= cfg_init_en ? init_data[gi*ACC_WIDTH +: ACC_WIDTH] : '0;
        end else if (v2_reg) begin
          acc_reg <= clamp_vec[gi] ? sat_val : acc_wide[ACC_WIDTH-1:0];
        end
      end

      // Result register only changes on the DRAIN->HOLD transition, so the
      // tile stays stable for as long as downstream stalls.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_reg <= '0;
        end else if (copy_out) begin
          out_reg <= acc_reg;
        end
      end

      assign out_data[gi*ACC_WIDTH +: ACC_WIDTH] = out_reg;
    end
  endgenerate

endmodule

// File: tb/tb_w4a8_tile_acc_engine.sv
// ---------------------------------------------------------------------------
// tb_w4a8_tile_acc_engine
//
// Directed bench for w4a8_tile_acc_engine (M=N=2, K=4). A reference model
// computes each tile from plain integer dot products with per-beat clamping;
// a compare process checks out_data and sat against it on every cycle that
// out_valid is high. Literal expectations pin the model for the key tiles,
// and handshake timing (in_ready drop, result latency, hold, release) is
// checked inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_w4a8_tile_acc_engine;

  localparam int A_WIDTH    = 8;
  localparam int B_WIDTH    = 4;
  localparam int ACC_WIDTH  = 32;
  localparam int M          = 2;
  localparam int N          = 2;
  localparam int K          = 4;
  localparam int MAX_KSTEPS = 256;
  localparam int KS_W       = $clog2(MAX_KSTEPS+1);

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         start = 1'b0;
  logic [KS_W-1:0]              cfg_ksteps = '0;
  logic                         cfg_b_unsigned = 1'b0;
  logic                         cfg_init_en = 1'b0;
  logic [M*N*ACC_WIDTH-1:0]     init_data = '0;
  logic                         in_valid = 1'b0;
  logic                         in_ready;
  logic [M*K*A_WIDTH-1:0]       a_data = '0;
  logic [N*K*B_WIDTH-1:0]       b_data = '0;
  logic                         out_valid;
  logic                         out_ready = 1'b0;
  logic [M*N*ACC_WIDTH-1:0]     out_data;
  logic                         sat;
  logic                         busy;

  int checks = 0;
  int failures = 0;

  int     ta [M][K];     // activations of the beat under test
  int     tw [N][K];     // weights as written (4-bit pattern taken from low bits)
  longint exp_c [M*N];   // model result tile
  bit     exp_sat;

  w4a8_tile_acc_engine #(
    .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .ACC_WIDTH(ACC_WIDTH),
    .M(M), .N(N), .K(K), .MAX_KSTEPS(MAX_KSTEPS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_ksteps(cfg_ksteps),
    .cfg_b_unsigned(cfg_b_unsigned), .cfg_init_en(cfg_init_en),
    .init_data(init_data), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .b_data(b_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .sat(sat), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: C = seed + sum over beats of dot(a_row_i, b_row_j),
  // clamped to the signed ACC_WIDTH range after every beat.
  task automatic model_tile(input int ks, input bit bu, input bit ie, input longint init_val);
    longint hi;
    longint lo;
    longint acc;
    longint dot;
    int     nib;
    int     bv;
    hi = (longint'(1) <<< (ACC_WIDTH-1)) - 1;
    lo = -(longint'(1) <<< (ACC_WIDTH-1));
    exp_sat = 1'b0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = ie ? init_val : 0;
        dot = 0;
        for (int k = 0; k < K; k++) begin
          nib = tw[j][k] & 15;
          bv  = bu ? nib : ((nib >= 8) ? nib - 16 : nib);
          dot += longint'(ta[i][k]) * longint'(bv);
        end
        for (int s = 0; s < ks; s++) begin
          acc += dot;
          if (acc > hi) begin acc = hi; exp_sat = 1'b1; end
          if (acc < lo) begin acc = lo; exp_sat = 1'b1; end
        end
        exp_c[i*N+j] = acc;
      end
    end
  endtask

  // Compare process: whenever a result is presented it must match the model.
  always @(negedge clk) begin : cmp
    logic [M*N*ACC_WIDTH-1:0] e;
    longint tmp;
    if (!rst && out_valid) begin
      for (int x = 0; x < M*N; x++) begin
        tmp = exp_c[x];
        e[x*ACC_WIDTH +: ACC_WIDTH] = tmp[ACC_WIDTH-1:0];
      end
      checks++;
      if (out_data !== e) begin
        failures++;
        $display("FAIL out_data actual=%h required=%h", out_data, e);
      end
      check("sat", longint'(sat), longint'(exp_sat));
    end
  end

  task automatic load_beat();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++)
        a_data[(i*K+k)*A_WIDTH +: A_WIDTH] = A_WIDTH'(ta[i][k]);
    for (int j = 0; j < N; j++)
      for (int k = 0; k < K; k++)
        b_data[(j*K+k)*B_WIDTH +: B_WIDTH] = B_WIDTH'(tw[j][k]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  longint'(in_ready), 0);
    check({tag, "_out_valid"}, longint'(out_valid), 0);
    check({tag, "_sat"},       longint'(sat), 0);
    check({tag, "_busy"},      longint'(busy), 0);
    check({tag, "_out_data"},  longint'(|out_data), 0);
  endtask

  // Run one tile of ks identical beats. vpat bit (n%8) is in_valid for the
  // n-th offered cycle. hold < 0: out_ready high from the start (handshake
  // on the first HOLD cycle); hold >= 0: stall that many cycles in HOLD with
  // start pulses, then release with start also high.
  task automatic do_tile(input int ks, input bit bu, input bit ie, input longint init_val,
                         input logic [7:0] vpat, input int hold);
    int  accepted;
    int  guard;
    int  p;
    int  nneg;
    bit  fire;
    model_tile(ks, bu, ie, init_val);
    load_beat();
    out_ready = (hold < 0);
    @(posedge clk); #1;
    start          = 1'b1;
    cfg_ksteps     = KS_W'(ks);
    cfg_b_unsigned = bu;
    cfg_init_en    = ie;
    for (int x = 0; x < M*N; x++) init_data[x*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(init_val);
    @(posedge clk); #1;
    start = 1'b0;
    accepted = 0; guard = 0; p = 0;
    while (accepted < ks && guard < 200) begin
      in_valid = vpat[p % 8];
      p++;
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (fire) accepted++;
      guard++;
    end
    check("beats_accepted", accepted, ks);
    nneg = 0;
    @(negedge clk); nneg = 1;
    check("in_ready_off", longint'(in_ready), 0);
    while (!out_valid && nneg < 30) begin
      @(negedge clk); nneg++;
    end
    check("out_valid_seen", longint'(out_valid), 1);
    check("latency", nneg - 1, (ks == 0) ? 1 : 3);
    if (hold < 0) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
    end else begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        start = (h % 2 == 0);
        @(negedge clk);
        check("hold_valid", longint'(out_valid), 1);
        check("hold_busy", longint'(busy), 1);
      end
      @(posedge clk); #1;
      start = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      out_ready = 1'b0;
    end
    @(negedge clk);
    check("release_valid", longint'(out_valid), 0);
    check("release_busy", longint'(busy), 0);
    $display("tile ks=%0d bu=%0d init_en=%0d init=%0d c00=%0d c01=%0d c10=%0d c11=%0d sat=%0d",
             ks, bu, ie, init_val, exp_c[0], exp_c[1], exp_c[2], exp_c[3], exp_sat);
  endtask

  task automatic set_test1();
    ta[0] = '{1, 2, 3, 4};
    ta[1] = '{-1, -1, -1, -1};
    tw[0] = '{1, 1, 1, 1};
    tw[1] = '{-8, 0, 0, 7};
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Signed weights, single beat
    set_test1();
    do_tile(1, 1'b0, 1'b0, 0, 8'hFF, 0);
    check("pin_t1_c00", exp_c[0], 10);
    check("pin_t1_c01", exp_c[1], 20);
    check("pin_t1_c10", exp_c[2], -4);
    check("pin_t1_c11", exp_c[3], 1);

    // Unsigned weights, handshake on the first HOLD cycle
    tw[1] = '{8, 0, 0, 7};
    do_tile(1, 1'b1, 1'b0, 0, 8'hFF, -1);
    check("pin_t2_c01", exp_c[1], 36);
    check("pin_t2_c11", exp_c[3], -15);

    // Four beats with in_valid gaps, seeded, then stalled in HOLD
    ta[0] = '{1, 2, 3, 4};
    ta[1] = '{1, 2, 3, 4};
    tw[0] = '{1, 1, 1, 1};
    tw[1] = '{1, 1, 1, 1};
    do_tile(4, 1'b0, 1'b1, 100, 8'b1100_1101, 5);
    check("pin_t3_c00", exp_c[0], 140);
    check("pin_t3_c11", exp_c[3], 140);

    // Positive saturation
    ta[0] = '{127, 127, 127, 127};
    ta[1] = '{127, 127, 127, 127};
    tw[0] = '{7, 7, 7, 7};
    tw[1] = '{7, 7, 7, 7};
    do_tile(2, 1'b0, 1'b1, 64'd2147483548, 8'hFF, 0);
    check("pin_sat_c00", exp_c[0], 64'd2147483647);
    check("pin_sat_flag", longint'(exp_sat), 1);

    // Following tile must start with sat clear
    set_test1();
    do_tile(1, 1'b0, 1'b0, 0, 8'hFF, 0);
    check("pin_nosat_flag", longint'(exp_sat), 0);

    // Zero beats: seed passes straight through
    do_tile(0, 1'b0, 1'b1, 55, 8'hFF, 0);
    check("pin_k0_c00", exp_c[0], 55);

    // Reset in the middle of RUN after 2 of 4 beats
    set_test1();
    load_beat();
    @(posedge clk); #1;
    start = 1'b1;
    cfg_ksteps = KS_W'(4);
    cfg_b_unsigned = 1'b0;
    cfg_init_en = 1'b1;
    for (int x = 0; x < M*N; x++) init_data[x*ACC_WIDTH +: ACC_WIDTH] = 32'd77;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrun_busy", longint'(busy), 1);
    check("midrun_in_ready", longint'(in_ready), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrun_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    $display("tile aborted by reset after 2 of 4 beats");

    // Fresh tile after reset shows no residue
    do_tile(1, 1'b0, 1'b0, 0, 8'hFF, 0);
    check("pin_post_rst_c01", exp_c[1], 20);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
